maxnet_controller: RTL and testbench

MAXNET_CONTROLLER -- requirements
Module: maxnet_controller

---
 rtl/maxnet_controller_if.sv | 34 +++
 rtl/maxnet_controller.sv | 114 +++++++++++
 tb/tb_maxnet_controller.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/maxnet_controller_if.sv
// maxnet_controller_if
//   Groups the controller's handshake and result signals.
//   slave  : controller side (samples start/o, drives everything else)
//   master : requester/neuron side (drives start/o, observes results)
//   start        - request one network evaluation
//   o[3:0]       - per-neuron nonzero flags (from the neurons' registered f)
//   mux          - neuron input select: 0 external, 1 feedback
//   ready/busy   - accept / in-progress status
//   done         - one-cycle completion pulse
//   winner_valid, winner, none_left, timeout - evaluation outcome
//   iter_count   - feedback iterations evaluated in the last/current run
interface maxnet_controller_if;
  logic       start;
  logic [3:0] o;
  logic       mux;
  logic       ready;
  logic       busy;
  logic       done;
  logic       winner_valid;
  logic [1:0] winner;
  logic       none_left;
  logic       timeout;
  logic [7:0] iter_count;

  modport master (
    output start, o,
    input  mux, ready, busy, done, winner_valid, winner, none_left, timeout, iter_count
  );

  modport slave (
    input  start, o,
    output mux, ready, busy, done, winner_valid, winner, none_left, timeout, iter_count
  );
endinterface

// File: rtl/maxnet_controller.sv
// maxnet_controller
//   Sequences a four-neuron MAXNET: loads external inputs, then iterates the
//   feedback path until exactly one neuron survives, all die, or MAX_ITER
//   iterations have been evaluated.
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset (wins over start)
//   bus  - maxnet_controller_if.slave (start/o in, status and results out)
//   MAX_ITER (1..255) - iteration limit before forced termination
module maxnet_controller #(
  parameter int MAX_ITER = 16
) (
  input logic                 clk,
  input logic                 rst,
  maxnet_controller_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] ITER = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [7:0] MAX_ITER_C = 8'(MAX_ITER);

  logic [1:0] state_q, state_d;
  logic [7:0] iter_q, iter_d;
  logic       winner_valid_q, winner_valid_d;
  logic [1:0] winner_q, winner_d;
  logic       none_left_q, none_left_d;
  logic       timeout_q, timeout_d;

  // Survivor count and index of the highest set flag; the index is only
  // consumed when exactly one flag is set, so priority order is irrelevant.
  logic [2:0] ones;
  logic [1:0] idx;

  always_comb begin
    ones = '0;
    idx  = '0;
    for (int i = 0; i < 4; i++) begin
      ones = ones + {2'b00, bus.o[i]};
      if (bus.o[i]) idx = 2'(i);
    end
  end

  always_comb begin
    state_d        = state_q;
    iter_d         = iter_q;
    winner_valid_d = winner_valid_q;
    winner_d       = winner_q;
    none_left_d    = none_left_q;
    timeout_d      = timeout_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d        = LOAD;
          iter_d         = '0;
          winner_valid_d = 1'b0;
          winner_d       = '0;
          none_left_d    = 1'b0;
          timeout_d      = 1'b0;
        end
      end
      LOAD: state_d = ITER;
      ITER: begin
        iter_d = iter_q + 8'd1;
        // Convergence is tested before the limit so a last-iteration winner
        // is reported as a winner, not a timeout.
        if (ones == 3'd1) begin
          state_d        = DONE;
          winner_valid_d = 1'b1;
          winner_d       = idx;
        end else if (ones == 3'd0) begin
          state_d     = DONE;
          none_left_d = 1'b1;
        end else if (iter_d == MAX_ITER_C) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      iter_q         <= '0;
      winner_valid_q <= 1'b0;
      winner_q       <= '0;
      none_left_q    <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      iter_q         <= iter_d;
      winner_valid_q <= winner_valid_d;
      winner_q       <= winner_d;
      none_left_q    <= none_left_d;
      timeout_q      <= timeout_d;
    end
  end

  // Status outputs decode registered state only.
  assign bus.ready        = (state_q == IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.mux          = (state_q == ITER) || (state_q == DONE);
  assign bus.done         = (state_q == DONE);
  assign bus.winner_valid = winner_valid_q;
  assign bus.winner       = winner_q;
  assign bus.none_left    = none_left_q;
  assign bus.timeout      = timeout_q;
  assign bus.iter_count   = iter_q;

endmodule

// File: tb/tb_maxnet_controller.sv
module tb_maxnet_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]      start_s;
  logic [2:0][3:0] o_s;
  logic [2:0]      mux_s, ready_s, busy_s, done_s, wv_s, nl_s, to_s;
  logic [2:0][1:0] winner_s;
  logic [2:0][7:0] iter_s;

  // Three instances cover MAX_ITER = 16, 4 and 2.
  function automatic int max_of(input int d);
    return (d == 0) ? 16 : (d == 1) ? 4 : 2;
  endfunction

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int M = (gi == 0) ? 16 : (gi == 1) ? 4 : 2;
      maxnet_controller_if bus ();
      assign bus.start     = start_s[gi];
      assign bus.o         = o_s[gi];
      assign mux_s[gi]     = bus.mux;
      assign ready_s[gi]   = bus.ready;
      assign busy_s[gi]    = bus.busy;
      assign done_s[gi]    = bus.done;
      assign wv_s[gi]      = bus.winner_valid;
      assign winner_s[gi]  = bus.winner;
      assign nl_s[gi]      = bus.none_left;
      assign to_s[gi]      = bus.timeout;
      assign iter_s[gi]    = bus.iter_count;
      maxnet_controller #(.MAX_ITER(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
      );
    end
  endgenerate

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected held results per instance.
  int exp_wv [3];
  int exp_w  [3];
  int exp_nl [3];
  int exp_to [3];
  int exp_it [3];

  logic [3:0] seq [1:255];

  task automatic clear_model();
    for (int d = 0; d < 3; d++) begin
      exp_wv[d] = 0; exp_w[d] = 0; exp_nl[d] = 0; exp_to[d] = 0; exp_it[d] = 0;
    end
  endtask

  task automatic check_results(input int d, input string ph);
    check({ph, "_winner_valid"}, int'(wv_s[d]), exp_wv[d]);
    check({ph, "_winner"},       int'(winner_s[d]), exp_w[d]);
    check({ph, "_none_left"},    int'(nl_s[d]), exp_nl[d]);
    check({ph, "_timeout"},      int'(to_s[d]), exp_to[d]);
    check({ph, "_iter_count"},   int'(iter_s[d]), exp_it[d]);
  endtask

  task automatic check_idle(input int d, input string ph);
    check({ph, "_ready"}, int'(ready_s[d]), 1);
    check({ph, "_busy"},  int'(busy_s[d]), 0);
    check({ph, "_mux"},   int'(mux_s[d]), 0);
    check({ph, "_done"},  int'(done_s[d]), 0);
    check_results(d, ph);
  endtask

  // One evaluation on instance d using seq[1..]. The model decides, from the
  // rules alone, which iteration terminates the run and with what outcome.
  task automatic run_txn(input int d, input string name);
    int m, n, pc;
    m = max_of(d);
    n = m;
    for (int k = 1; k <= m; k++) begin
      if ($countones(seq[k]) <= 1) begin
        n = k;
        break;
      end
    end
    pc = $countones(seq[n]);

    @(negedge clk);
    check_idle(d, {name, "_pre"});
    start_s[d] = 1'b1;
    o_s[d]     = 4'($urandom);
    @(posedge clk);
    @(negedge clk);
    start_s[d] = 1'($urandom);
    check({name, "_load_busy"}, int'(busy_s[d]), 1);
    check({name, "_load_mux"},  int'(mux_s[d]), 0);
    check({name, "_load_ready"}, int'(ready_s[d]), 0);
    exp_wv[d] = 0; exp_w[d] = 0; exp_nl[d] = 0; exp_to[d] = 0; exp_it[d] = 0;
    check_results(d, {name, "_load"});

    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      @(negedge clk);
      check({name, "_iter_mux"},  int'(mux_s[d]), 1);
      check({name, "_iter_done"}, int'(done_s[d]), 0);
      check({name, "_iter_busy"}, int'(busy_s[d]), 1);
      check({name, "_iter_cnt"},  int'(iter_s[d]), k - 1);
      o_s[d]     = seq[k];
      start_s[d] = 1'($urandom);
    end

    @(posedge clk);
    @(negedge clk);
    start_s[d] = 1'($urandom);
    o_s[d]     = 4'($urandom);
    exp_it[d] = n;
    if (pc == 1) begin
      exp_wv[d] = 1;
      for (int i = 0; i < 4; i++) if (seq[n][i]) exp_w[d] = i;
    end else if (pc == 0) begin
      exp_nl[d] = 1;
    end else begin
      exp_to[d] = 1;
    end
    check({name, "_done"},      int'(done_s[d]), 1);
    check({name, "_done_mux"},  int'(mux_s[d]), 1);
    check({name, "_done_busy"}, int'(busy_s[d]), 1);
    check_results(d, {name, "_done"});
    $display("txn %s dut=%0d max=%0d iters=%0d wv=%0d w=%0d nl=%0d to=%0d", name, d, m, n,
             exp_wv[d], exp_w[d], exp_nl[d], exp_to[d]);

    @(posedge clk);
    @(negedge clk);
    start_s[d] = 1'b0;
    check_idle(d, {name, "_post"});
  endtask

  task automatic set_seq(input logic [3:0] v, input int from, input int to);
    for (int k = from; k <= to; k++) seq[k] = v;
  endtask

  initial begin
    rst     = 1'b1;
    start_s = '1;
    o_s     = '0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    start_s = '0;
    for (int d = 0; d < 3; d++) check_idle(d, "reset");

    // Single winner after two full iterations.
    set_seq(4'b1111, 1, 2); seq[3] = 4'b0100; set_seq(4'b1111, 4, 255);
    run_txn(0, "single_winner");
    // Immediate convergence.
    seq[1] = 4'b1000;
    run_txn(0, "immediate");
    // All neurons die.
    seq[1] = 4'b0011; seq[2] = 4'b0000;
    run_txn(0, "all_die");
    // Timeout at MAX_ITER=4.
    set_seq(4'b0110, 1, 255);
    run_txn(1, "timeout4");
    // Timeout at MAX_ITER=16.
    run_txn(0, "timeout16");
    // Convergence on the last allowed iteration beats timeout.
    seq[1] = 4'b0110; seq[2] = 4'b0001;
    run_txn(2, "priority");
    seq[2] = 4'b0000;
    run_txn(2, "priority_none");

    // Reset in the middle of ITER, coincident with start.
    @(negedge clk);
    start_s[0] = 1'b1;
    o_s[0]     = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    start_s[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_run_iter1_mux", int'(mux_s[0]), 1);
    @(posedge clk);
    @(negedge clk);
    check("rst_run_iter2_cnt", int'(iter_s[0]), 1);
    rst        = 1'b1;
    start_s[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst        = 1'b0;
    start_s[0] = 1'b0;
    clear_model();
    check_idle(0, "rst_mid");
    @(posedge clk);
    @(negedge clk);
    check_idle(0, "rst_mid_hold");
    seq[1] = 4'b1111; seq[2] = 4'b0010;
    run_txn(0, "after_rst");

    // Randomized runs across all three instances.
    for (int t = 0; t < 60; t++) begin
      int d;
      d = $urandom_range(0, 2);
      for (int k = 1; k <= 16; k++) begin
        logic [3:0] v;
        v = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 9) < 8) begin
          for (int g = 0; g < 32 && $countones(v) < 2; g++) v = 4'($urandom_range(0, 15));
          if ($countones(v) < 2) v = 4'b1100;
        end
        seq[k] = v;
      end
      run_txn(d, $sformatf("rand%0d", t));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        o_s[d] = 4'($urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
